// File: rtl/ndp_sequencer.sv
// ndp_sequencer: runs one NDP job (clear, feed beats, drain, present result).
// Define NDP_SEQ_TIMEOUT_EN to add a DRAIN watchdog that raises err_timeout.
module ndp_sequencer #(
  parameter int A_W            = 32,
  parameter int B_W            = 2048,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           start_ready,
  input  logic [15:0]    job_len,
  input  logic [1:0]     job_mode,
  input  logic           src_valid,
  output logic           src_ready,
  input  logic [A_W-1:0] src_a,
  input  logic [B_W-1:0] src_b,
  input  logic           abort,
  output logic           ndp_clear,
  output logic [A_W-1:0] ndp_in_a,
  output logic [B_W-1:0] ndp_in_b,
  output logic           ndp_in_done_flag,
  output logic [1:0]     ndp_simd_ctrl,
  input  logic           ndp_calc_done,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           err_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t          state_r, fsm_next_s, next_s;
  logic [15:0]     job_len_r, beat_cnt_r;
  logic [1:0]      simd_ctrl_r;
  logic            start_ready_r, src_ready_r, ndp_clear_r, done_flag_r, res_valid_r;
  logic [A_W-1:0]  ndp_in_a_r;
  logic [B_W-1:0]  ndp_in_b_r;
  logic            abort_s, feed_valid_s, accept_s, job_start_s, timeout_s;

  assign abort_s      = abort && (state_r != IDLE);
  assign accept_s     = feed_valid_s && !abort_s;
  assign job_start_s  = (state_r == IDLE) && (next_s == CLEAR);

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    fsm_next_s   = state_r;
    feed_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (job_len != 16'd0)) fsm_next_s = CLEAR;
        else                             fsm_next_s = IDLE;
      end
      CLEAR: fsm_next_s = FEED;
      FEED: begin
        feed_valid_s = src_valid;
        if (src_valid && ((beat_cnt_r + 16'd1) == job_len_r)) fsm_next_s = DRAIN;
        else                                                  fsm_next_s = FEED;
      end
      DRAIN: begin
        if (ndp_calc_done)  fsm_next_s = RESULT;
        else if (timeout_s) fsm_next_s = IDLE;
        else                fsm_next_s = DRAIN;
      end
      RESULT: begin
        if (res_ready) fsm_next_s = IDLE;
        else           fsm_next_s = RESULT;
      end
      default: fsm_next_s = IDLE;
    endcase
    next_s = abort_s ? IDLE : fsm_next_s;
  end

  // State, job latches and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      job_len_r     <= 16'd0;
      beat_cnt_r    <= 16'd0;
      simd_ctrl_r   <= 2'd0;
      start_ready_r <= 1'b1;
      src_ready_r   <= 1'b0;
      ndp_clear_r   <= 1'b0;
      done_flag_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      ndp_in_a_r    <= '0;
      ndp_in_b_r    <= '0;
    end else begin
      state_r <= next_s;
      if (job_start_s) begin
        job_len_r   <= job_len;
        simd_ctrl_r <= job_mode;
      end
      if (next_s == FEED) beat_cnt_r <= accept_s ? (beat_cnt_r + 16'd1) : beat_cnt_r;
      else                beat_cnt_r <= 16'd0;
      start_ready_r <= (next_s == IDLE);
      src_ready_r   <= (next_s == FEED);
      ndp_clear_r   <= (next_s == CLEAR) || abort_s || timeout_s;
      // The done flag trails the final beat so the NDP never sees both together.
      done_flag_r   <= ((next_s == DRAIN) || (next_s == RESULT)) && !accept_s;
      res_valid_r   <= (next_s == RESULT);
      ndp_in_a_r    <= accept_s ? src_a : '0;
      ndp_in_b_r    <= accept_s ? src_b : '0;
    end
  end

`ifdef NDP_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] drain_cnt_r;
  logic          err_timeout_r;

  assign timeout_s = (state_r == DRAIN) && !ndp_calc_done &&
                     (drain_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Drain watchdog counter and sticky error, cleared by the next accepted job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt_r   <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      if ((state_r == DRAIN) && (next_s == DRAIN)) drain_cnt_r <= drain_cnt_r + TW'(1);
      else                                         drain_cnt_r <= '0;
      if (job_start_s)                err_timeout_r <= 1'b0;
      else if (timeout_s && !abort_s) err_timeout_r <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_r;
`else
  assign timeout_s   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign start_ready      = start_ready_r;
  assign src_ready        = src_ready_r;
  assign ndp_clear        = ndp_clear_r;
  assign ndp_in_a         = ndp_in_a_r;
  assign ndp_in_b         = ndp_in_b_r;
  assign ndp_in_done_flag = done_flag_r;
  assign ndp_simd_ctrl    = simd_ctrl_r;
  assign res_valid        = res_valid_r;

endmodule

// File: tb/tb_ndp_sequencer.sv
// Directed self-checking bench for ndp_sequencer; the timeout scenario
// follows NDP_SEQ_TIMEOUT_EN the same way the design does.
module tb_ndp_sequencer;
  localparam int A_W = 32;
  localparam int B_W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0, src_valid = 1'b0, abort = 1'b0;
  logic           ndp_calc_done = 1'b0, res_ready = 1'b0;
  logic [15:0]    job_len = 16'd0;
  logic [1:0]     job_mode = 2'd0;
  logic [A_W-1:0] src_a = '0;
  logic [B_W-1:0] src_b = '0;
  logic           start_ready, src_ready, ndp_clear, ndp_in_done_flag, res_valid, err_timeout;
  logic [A_W-1:0] ndp_in_a;
  logic [B_W-1:0] ndp_in_b;
  logic [1:0]     ndp_simd_ctrl;

  int check_cnt = 0;
  int fail_cnt  = 0;

  ndp_sequencer #(.A_W(A_W), .B_W(B_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(rst_n), .start(start), .start_ready(start_ready),
    .job_len(job_len), .job_mode(job_mode), .src_valid(src_valid),
    .src_ready(src_ready), .src_a(src_a), .src_b(src_b), .abort(abort),
    .ndp_clear(ndp_clear), .ndp_in_a(ndp_in_a), .ndp_in_b(ndp_in_b),
    .ndp_in_done_flag(ndp_in_done_flag), .ndp_simd_ctrl(ndp_simd_ctrl),
    .ndp_calc_done(ndp_calc_done), .res_valid(res_valid),
    .res_ready(res_ready), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] len, input logic [1:0] mode);
    start = 1'b1; job_len = len; job_mode = mode;
    step();
    start = 1'b0;
    check_eq("clear_pulse", 64'(ndp_clear), 64'd1);
    check_eq("busy_start_ready", 64'(start_ready), 64'd0);
    check_eq("simd_latched", 64'(ndp_simd_ctrl), 64'(mode));
    check_eq("clear_src_ready", 64'(src_ready), 64'd0);
    step();
    check_eq("clear_one_cycle", 64'(ndp_clear), 64'd0);
    check_eq("feed_src_ready", 64'(src_ready), 64'd1);
  endtask

  initial begin
    logic [5:0] pat;
    logic [A_W-1:0] va;

    // Reset state
    step(); step();
    check_eq("rst_start_ready", 64'(start_ready), 64'd1);
    check_eq("rst_src_ready", 64'(src_ready), 64'd0);
    check_eq("rst_clear", 64'(ndp_clear), 64'd0);
    check_eq("rst_done", 64'(ndp_in_done_flag), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_err", 64'(err_timeout), 64'd0);
    check_eq("rst_simd", 64'(ndp_simd_ctrl), 64'd0);
    check_eq("rst_in_a", 64'(ndp_in_a), 64'd0);
    rst_n = 1'b1;
    step();
    check_eq("rst_exit_clear", 64'(ndp_clear), 64'd0);

    // Zero-length start is ignored
    start = 1'b1; job_len = 16'd0; job_mode = 2'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("len0_start_ready", 64'(start_ready), 64'd1);
      check_eq("len0_clear", 64'(ndp_clear), 64'd0);
      check_eq("len0_simd", 64'(ndp_simd_ctrl), 64'd0);
    end
    start = 1'b0;

    // Three beats back to back, long calc, result
    start_job(16'd3, 2'd2);
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      va = 32'hA000_0001 + 32'(i);
      src_a = va; src_b = {~va, va};
      step();
      check_eq("j3_in_a", 64'(ndp_in_a), 64'(va));
      check_eq("j3_in_b", 64'(ndp_in_b), {~va, va});
      check_eq("j3_done_low", 64'(ndp_in_done_flag), 64'd0);
    end
    check_eq("j3_drain_src_ready", 64'(src_ready), 64'd0);
    src_valid = 1'b0;
    step();
    check_eq("j3_done_high", 64'(ndp_in_done_flag), 64'd1);
    check_eq("j3_drain_bus", 64'(ndp_in_a), 64'd0);
    for (int i = 0; i < 259; i++) step();
    check_eq("j3_wait_res", 64'(res_valid), 64'd0);
    ndp_calc_done = 1'b1;
    step();
    ndp_calc_done = 1'b0;
    check_eq("j3_res_valid", 64'(res_valid), 64'd1);
    check_eq("j3_res_done", 64'(ndp_in_done_flag), 64'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_eq("j3_idle", 64'(start_ready), 64'd1);
    check_eq("j3_res_drop", 64'(res_valid), 64'd0);
    check_eq("j3_done_drop", 64'(ndp_in_done_flag), 64'd0);

    // Four beats with bubbles: valid pattern 1,0,1,1,0,1 (index 0 first)
    start_job(16'd4, 2'd1);
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      va = 32'hB000_0010 + 32'(i);
      src_valid = pat[i]; src_a = va; src_b = {va, va};
      step();
      check_eq("j4_in_a", 64'(ndp_in_a), pat[i] ? 64'(va) : 64'd0);
      check_eq("j4_in_b", 64'(ndp_in_b), pat[i] ? {va, va} : 64'd0);
    end
    src_valid = 1'b0;
    check_eq("j4_drain_src_ready", 64'(src_ready), 64'd0);

    // Result held while res_ready stays low
    ndp_calc_done = 1'b1;
    step();
    ndp_calc_done = 1'b0;
    check_eq("hold_res_valid", 64'(res_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("hold_res_valid", 64'(res_valid), 64'd1);
      check_eq("hold_done", 64'(ndp_in_done_flag), 64'd1);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_eq("hold_idle", 64'(start_ready), 64'd1);
    check_eq("hold_res_drop", 64'(res_valid), 64'd0);

    // Abort on the last beat
    start_job(16'd2, 2'd0);
    src_valid = 1'b1; src_a = 32'hC000_0001; src_b = 64'd5;
    step();
    check_eq("ab_beat1", 64'(ndp_in_a), 64'hC000_0001);
    src_a = 32'hC000_0002; abort = 1'b1;
    step();
    abort = 1'b0; src_valid = 1'b0;
    check_eq("ab_idle", 64'(start_ready), 64'd1);
    check_eq("ab_clear", 64'(ndp_clear), 64'd1);
    check_eq("ab_bus_zero", 64'(ndp_in_a), 64'd0);
    check_eq("ab_done", 64'(ndp_in_done_flag), 64'd0);
    check_eq("ab_src_ready", 64'(src_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("ab_clear_once", 64'(ndp_clear), 64'd0);
      check_eq("ab_no_drain", 64'(ndp_in_done_flag), 64'd0);
      check_eq("ab_stay_idle", 64'(start_ready), 64'd1);
    end

    // Drain watchdog
    start_job(16'd1, 2'd3);
    src_valid = 1'b1; src_a = 32'hD000_0001;
    step();
    src_valid = 1'b0;
`ifdef NDP_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq("to_done", 64'(ndp_in_done_flag), 64'd1);
      check_eq("to_err_low", 64'(err_timeout), 64'd0);
    end
    step();
    check_eq("to_err_set", 64'(err_timeout), 64'd1);
    check_eq("to_clear", 64'(ndp_clear), 64'd1);
    check_eq("to_idle", 64'(start_ready), 64'd1);
    check_eq("to_done_drop", 64'(ndp_in_done_flag), 64'd0);
    step();
    check_eq("to_clear_once", 64'(ndp_clear), 64'd0);
    check_eq("to_err_sticky", 64'(err_timeout), 64'd1);
    start = 1'b1; job_len = 16'd1; job_mode = 2'd1;
    step();
    start = 1'b0;
    check_eq("to_err_cleared", 64'(err_timeout), 64'd0);
    check_eq("to_new_simd", 64'(ndp_simd_ctrl), 64'd1);
`else
    for (int i = 0; i < 40; i++) step();
    check_eq("nto_err", 64'(err_timeout), 64'd0);
    check_eq("nto_still_drain", 64'(ndp_in_done_flag), 64'd1);
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("end_idle", 64'(start_ready), 64'd1);
    check_eq("end_clear", 64'(ndp_clear), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/ndp_sequencer.md
NDP_SEQUENCER -- requirements
Module: ndp_sequencer

Interface
REQ-001 The module SHALL provide parameter A_W, default 32, the activation bus width (ARR_HEIGHT*SYS_HEIGHT*WIDTH).
REQ-002 The module SHALL provide parameter B_W, default 2048, the expert bus width (ARR_WIDTH*SYS_WIDTH*WIDTH).
REQ-003 The module SHALL provide parameter TIMEOUT_CYCLES, default 1024, the maximum cycles allowed in DRAIN.
REQ-004 The module SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 The module SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port start  input  1  job request.
REQ-007 The module SHALL have port start_ready  output  1  high only in IDLE.
REQ-008 The module SHALL have port job_len  input  16  number of vector-pair beats in the job.
REQ-009 The module SHALL have port job_mode  input  2  SIMD mode for the job.
REQ-010 The module SHALL have port src_valid  input  1  source beat valid.
REQ-011 The module SHALL have port src_ready  output  1  sequencer accepts beat.
REQ-012 The module SHALL have port src_a  input  A_W  activation vector.
REQ-013 The module SHALL have port src_b  input  B_W  expert vector.
REQ-014 The module SHALL have port abort  input  1  cancel current job.
REQ-015 The module SHALL have port ndp_clear  output  1  active-high clear pulse to the NDP unit.
REQ-016 The module SHALL have port ndp_in_a  output  A_W  registered activation to the NDP unit.
REQ-017 The module SHALL have port ndp_in_b  output  B_W  registered expert vector to the NDP unit.
REQ-018 The module SHALL have port ndp_in_done_flag  output  1  end-of-input flag to the NDP unit.
REQ-019 The module SHALL have port ndp_simd_ctrl  output  2  SIMD control to the NDP unit.
REQ-020 The module SHALL have port ndp_calc_done  input  1  calculation-done flag from the NDP unit.
REQ-021 The module SHALL have port res_valid  output  1  NDP result (out_c) valid for capture.
REQ-022 The module SHALL have port res_ready  input  1  consumer captured result.
REQ-023 The module SHALL have port err_timeout  output  1  sticky drain-timeout error.

Function
REQ-024 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, RESULT.
REQ-025 IDLE SHALL move to CLEAR when start=1 and job_len!=0, latching job_len, latching job_mode into ndp_simd_ctrl (held stable until the next accepted start), and clearing err_timeout.
REQ-026 start with job_len=0 SHALL be ignored: no state change, no outputs change.
REQ-027 CLEAR SHALL last exactly one cycle with ndp_clear=1, then go to FEED; src_ready therefore rises two cycles after start is accepted.
REQ-028 FEED SHALL drive src_ready=1; on src_valid&src_ready, ndp_in_a/ndp_in_b SHALL take src_a/src_b on the next cycle and the beat counter SHALL increment; on any non-accepting cycle both buses SHALL be all-zero (a zero bubble).
REQ-029 Acceptance of beat number job_len SHALL move FEED to DRAIN; src_ready SHALL be 0 in every state except FEED.
REQ-030 DRAIN SHALL hold ndp_in_done_flag=1 and zero buses, and SHALL go to RESULT on the first cycle ndp_calc_done=1.
REQ-031 RESULT SHALL hold res_valid=1 and ndp_in_done_flag=1 until res_ready=1, then go to IDLE with both deasserted; res_ready in the first RESULT cycle SHALL complete the handshake.
REQ-032 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with a one-cycle ndp_clear pulse, zero buses, and deasserted flags; abort SHALL take priority over last-beat, calc_done, and res_ready in the same cycle; abort in IDLE SHALL be ignored.

Reset
REQ-033 While reset=0, the FSM SHALL be in IDLE, all outputs SHALL be 0 except start_ready=1, and the counters SHALL be 0; mid-job reset SHALL discard the job.
REQ-034 Reset deassertion SHALL take effect synchronously with clk; ndp_clear SHALL not pulse on reset exit.

Configuration
REQ-035 With NDP_SEQ_TIMEOUT_EN defined, a DRAIN cycle counter SHALL run; when it reaches TIMEOUT_CYCLES without ndp_calc_done, err_timeout SHALL set, the FSM SHALL go to IDLE, and ndp_clear SHALL pulse once.
REQ-036 Without NDP_SEQ_TIMEOUT_EN, there SHALL be no counter, err_timeout SHALL be tied 0, and DRAIN SHALL wait indefinitely.

Verification
REQ-037 The bench SHALL check: job_len=3 with src_valid held high -> ndp_in_a carries 3 consecutive beats, then ndp_in_done_flag=1 the cycle after; ndp_calc_done 260 cycles later -> res_valid next cycle.
REQ-038 The bench SHALL check: job_len=4 with src_valid pattern 1,0,1,1,0,1 -> exactly 4 nonzero beats plus 2 all-zero bubbles in order.
REQ-039 The bench SHALL check: res_ready low for 5 cycles -> res_valid and ndp_in_done_flag held 5 cycles, IDLE one cycle after res_ready=1.
REQ-040 The bench SHALL check: abort on the same cycle as the last beat -> IDLE, one ndp_clear pulse, no DRAIN entry.
REQ-041 The bench SHALL check: with the macro, TIMEOUT_CYCLES=16 and no calc_done -> err_timeout=1 after 16 DRAIN cycles; the next start clears it.
REQ-042 The bench SHALL check: start with job_len=0 -> start_ready stays 1 and no ndp_clear pulse.
